// File: rtl/i2c_slave_regmap.sv
// Byte-wide register file behind an I2C slave byte stream: the first written byte
// of a transfer sets the register pointer, later bytes store data and auto-increment it.
module i2c_slave_regmap #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  input  logic                    bus_addressed,
  input  logic                    hw_we,
  input  logic [ADDR_WIDTH-1:0]   hw_addr,
  input  logic [7:0]              hw_data,
  output logic                    reg_wr_pulse,
  output logic [ADDR_WIDTH-1:0]   reg_wr_addr,
  output logic [7:0]              reg_wr_data,
  output logic [ADDR_WIDTH-1:0]   ptr,
  output logic [8*(2**ADDR_WIDTH)-1:0] regs_flat
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic {ST_PTR, ST_DATA} state_t;

  state_t      state;
  logic [7:0]  regs [DEPTH];
  logic        bus_addressed_p1;
  logic        wr_hs;
  logic        rd_hs;
  logic        bus_fall;

  assign s_axis_tready = rst_n;
  assign m_axis_tvalid = rst_n;
  assign m_axis_tlast  = 1'b0;
  assign m_axis_tdata  = regs[ptr];

  assign wr_hs    = s_axis_tvalid & s_axis_tready;
  assign rd_hs    = m_axis_tvalid & m_axis_tready;
  assign bus_fall = bus_addressed_p1 & ~bus_addressed;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = regs[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_PTR;
      ptr              <= '0;
      bus_addressed_p1 <= 1'b0;
      reg_wr_pulse     <= 1'b0;
      reg_wr_addr      <= '0;
      reg_wr_data      <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      bus_addressed_p1 <= bus_addressed;
      reg_wr_pulse     <= 1'b0;
      // Fabric write first so a same-index I2C data write below overrides it.
      if (hw_we) regs[hw_addr] <= hw_data;
      case (state)
        ST_PTR: begin
          if (wr_hs) begin
            ptr   <= s_axis_tdata[ADDR_WIDTH-1:0];
            state <= s_axis_tlast ? ST_PTR : ST_DATA;
          end else if (rd_hs) begin
            ptr <= ptr + PTR_ONE;
          end
        end
        ST_DATA: begin
          if (wr_hs) begin
            regs[ptr]    <= s_axis_tdata;
            reg_wr_pulse <= 1'b1;
            reg_wr_addr  <= ptr;
            reg_wr_data  <= s_axis_tdata;
            ptr          <= ptr + PTR_ONE;
            if (s_axis_tlast) state <= ST_PTR;
          end else if (rd_hs) begin
            ptr <= ptr + PTR_ONE;
          end
        end
        default: state <= ST_PTR;
      endcase
      // Master releasing the slave ends the transfer; the pointer is kept.
      if (bus_fall) state <= ST_PTR;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Directed bench for i2c_slave_regmap: pointer/data writes, reads with wrap,
// bus release, fabric write collision, simultaneous handshakes and reset.
module tb_i2c_slave_regmap;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              bus_addressed;
  logic              hw_we;
  logic [AW-1:0]     hw_addr;
  logic [7:0]        hw_data;
  logic              reg_wr_pulse;
  logic [AW-1:0]     reg_wr_addr;
  logic [7:0]        reg_wr_data;
  logic [AW-1:0]     ptr;
  logic [8*DEPTH-1:0] regs_flat;

  int pass_cnt = 0;
  int total    = 0;

  i2c_slave_regmap #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .bus_addressed(bus_addressed),
    .hw_we(hw_we), .hw_addr(hw_addr), .hw_data(hw_data),
    .reg_wr_pulse(reg_wr_pulse), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .ptr(ptr), .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] reg_at(input int i);
    return regs_flat[8*i +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic last);
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic hw_write(input logic [AW-1:0] a, input logic [7:0] d);
    hw_we = 1'b1; hw_addr = a; hw_data = d;
    tick();
    hw_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (s_axis_tready !== 1'b0) $display("FAIL rst_tready got=%0b exp=0", s_axis_tready); else pass_cnt++;
    total++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid got=%0b exp=0", m_axis_tvalid); else pass_cnt++;
    total++; if (ptr !== 4'h0) $display("FAIL rst_ptr got=%0h exp=0", ptr); else pass_cnt++;
    total++; if (regs_flat !== '0) $display("FAIL rst_regs got=%032h exp=0", regs_flat); else pass_cnt++;
    total++; if ({reg_wr_pulse, reg_wr_addr, reg_wr_data} !== 13'h0) $display("FAIL rst_wrinfo got=%0h exp=0", {reg_wr_pulse, reg_wr_addr, reg_wr_data}); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total++; if (s_axis_tready !== 1'b1) $display("FAIL run_tready got=%0b exp=1", s_axis_tready); else pass_cnt++;
    total++; if (m_axis_tvalid !== 1'b1) $display("FAIL run_tvalid got=%0b exp=1", m_axis_tvalid); else pass_cnt++;
    total++; if (m_axis_tlast !== 1'b0) $display("FAIL m_tlast got=%0b exp=0", m_axis_tlast); else pass_cnt++;
  endtask

  task automatic test_basic_write();
    wr_byte(8'h03, 1'b0);
    total++; if (reg_wr_pulse !== 1'b0) $display("FAIL bw_ptr_nopulse got=%0b exp=0", reg_wr_pulse); else pass_cnt++;
    wr_byte(8'hA5, 1'b0);
    total++; if ({reg_wr_pulse, reg_wr_addr, reg_wr_data} !== {1'b1, 4'h3, 8'hA5}) $display("FAIL bw_pulse1 got=%0h exp=%0h", {reg_wr_pulse, reg_wr_addr, reg_wr_data}, {1'b1, 4'h3, 8'hA5}); else pass_cnt++;
    wr_byte(8'h5A, 1'b1);
    total++; if ({reg_wr_pulse, reg_wr_addr, reg_wr_data} !== {1'b1, 4'h4, 8'h5A}) $display("FAIL bw_pulse2 got=%0h exp=%0h", {reg_wr_pulse, reg_wr_addr, reg_wr_data}, {1'b1, 4'h4, 8'h5A}); else pass_cnt++;
    tick();
    total++; if (reg_wr_pulse !== 1'b0) $display("FAIL bw_pulse_end got=%0b exp=0", reg_wr_pulse); else pass_cnt++;
    total++; if (reg_at(3) !== 8'hA5) $display("FAIL bw_reg3 got=%02h exp=a5", reg_at(3)); else pass_cnt++;
    total++; if (reg_at(4) !== 8'h5A) $display("FAIL bw_reg4 got=%02h exp=5a", reg_at(4)); else pass_cnt++;
    total++; if (ptr !== 4'h5) $display("FAIL bw_ptr got=%0h exp=5", ptr); else pass_cnt++;
    // Back in pointer state: next byte loads the pointer instead of writing reg[5].
    wr_byte(8'h02, 1'b1);
    total++; if (ptr !== 4'h2 || reg_at(5) !== 8'h00) $display("FAIL bw_state got ptr=%0h r5=%02h exp ptr=2 r5=00", ptr, reg_at(5)); else pass_cnt++;
  endtask

  task automatic test_read_wrap();
    hw_write(4'hE, 8'h11);
    hw_write(4'hF, 8'h22);
    hw_write(4'h0, 8'h33);
    wr_byte(8'h0E, 1'b1);
    total++; if (m_axis_tdata !== 8'h11) $display("FAIL rd0 got=%02h exp=11", m_axis_tdata); else pass_cnt++;
    m_axis_tready = 1'b1;
    tick();
    total++; if (m_axis_tdata !== 8'h22) $display("FAIL rd1 got=%02h exp=22", m_axis_tdata); else pass_cnt++;
    tick();
    total++; if (m_axis_tdata !== 8'h33) $display("FAIL rd2 got=%02h exp=33", m_axis_tdata); else pass_cnt++;
    tick();
    m_axis_tready = 1'b0;
    total++; if (ptr !== 4'h1) $display("FAIL rd_ptr got=%0h exp=1", ptr); else pass_cnt++;
    total++; if ({reg_at(14), reg_at(15), reg_at(0)} !== 24'h112233) $display("FAIL rd_regs got=%06h exp=112233", {reg_at(14), reg_at(15), reg_at(0)}); else pass_cnt++;
  endtask

  task automatic test_bus_release();
    logic [8*DEPTH-1:0] snap;
    snap = regs_flat;
    wr_byte(8'h02, 1'b0);
    bus_addressed = 1'b0;
    tick();
    bus_addressed = 1'b1;
    tick();
    wr_byte(8'h07, 1'b1);
    total++; if (ptr !== 4'h7) $display("FAIL br_ptr got=%0h exp=7", ptr); else pass_cnt++;
    total++; if (reg_wr_pulse !== 1'b0) $display("FAIL br_pulse got=%0b exp=0", reg_wr_pulse); else pass_cnt++;
    total++; if (regs_flat !== snap) $display("FAIL br_regs got=%032h exp=%032h", regs_flat, snap); else pass_cnt++;
  endtask

  task automatic test_hw_collision();
    wr_byte(8'h05, 1'b0);
    hw_we = 1'b1; hw_addr = 4'h5; hw_data = 8'hFF;
    wr_byte(8'h44, 1'b1);
    hw_we = 1'b0;
    total++; if (reg_at(5) !== 8'h44) $display("FAIL hw_coll got=%02h exp=44", reg_at(5)); else pass_cnt++;
    total++; if ({reg_wr_pulse, reg_wr_addr, reg_wr_data} !== {1'b1, 4'h5, 8'h44}) $display("FAIL hw_coll_pulse got=%0h exp=%0h", {reg_wr_pulse, reg_wr_addr, reg_wr_data}, {1'b1, 4'h5, 8'h44}); else pass_cnt++;
    hw_write(4'h6, 8'h66);
    total++; if (reg_at(6) !== 8'h66) $display("FAIL hw_reg6 got=%02h exp=66", reg_at(6)); else pass_cnt++;
    total++; if (reg_wr_pulse !== 1'b0) $display("FAIL hw_nopulse got=%0b exp=0", reg_wr_pulse); else pass_cnt++;
  endtask

  task automatic test_simul_rw();
    hw_write(4'h8, 8'h77);
    wr_byte(8'h08, 1'b0);
    m_axis_tready = 1'b1;
    s_axis_tdata = 8'hBB; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    total++; if (m_axis_tdata !== 8'h77) $display("FAIL sim_rd_old got=%02h exp=77", m_axis_tdata); else pass_cnt++;
    tick();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    total++; if (reg_at(8) !== 8'hBB) $display("FAIL sim_reg8 got=%02h exp=bb", reg_at(8)); else pass_cnt++;
    total++; if (ptr !== 4'h9) $display("FAIL sim_ptr_data got=%0h exp=9", ptr); else pass_cnt++;
    wr_byte(8'hCC, 1'b1);
    m_axis_tready = 1'b1;
    wr_byte(8'h03, 1'b1);
    m_axis_tready = 1'b0;
    total++; if (ptr !== 4'h3) $display("FAIL sim_ptr_load got=%0h exp=3", ptr); else pass_cnt++;
    total++; if (reg_at(9) !== 8'hCC) $display("FAIL sim_reg9 got=%02h exp=cc", reg_at(9)); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    wr_byte(8'h01, 1'b0);
    wr_byte(8'h99, 1'b0);
    total++; if (reg_at(1) !== 8'h99) $display("FAIL rm_pre got=%02h exp=99", reg_at(1)); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total++; if (regs_flat !== '0) $display("FAIL rm_regs got=%032h exp=0", regs_flat); else pass_cnt++;
    total++; if (ptr !== 4'h0) $display("FAIL rm_ptr got=%0h exp=0", ptr); else pass_cnt++;
    total++; if ({reg_wr_pulse, reg_wr_addr, reg_wr_data} !== 13'h0) $display("FAIL rm_wrinfo got=%0h exp=0", {reg_wr_pulse, reg_wr_addr, reg_wr_data}); else pass_cnt++;
    rst_n = 1'b1;
    wr_byte(8'h08, 1'b1);
    total++; if (ptr !== 4'h8) $display("FAIL rm_newptr got=%0h exp=8", ptr); else pass_cnt++;
    total++; if (regs_flat !== '0) $display("FAIL rm_nowrite got=%032h exp=0", regs_flat); else pass_cnt++;
  endtask

  task automatic test_ptr_mask();
    wr_byte(8'h1F, 1'b1);
    total++; if (ptr !== 4'hF) $display("FAIL pm_ptr got=%0h exp=f", ptr); else pass_cnt++;
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    total++; if (ptr !== 4'h0) $display("FAIL pm_rdwrap got=%0h exp=0", ptr); else pass_cnt++;
    wr_byte(8'h0F, 1'b0);
    wr_byte(8'hAB, 1'b1);
    total++; if (ptr !== 4'h0 || reg_at(15) !== 8'hAB) $display("FAIL pm_wrwrap got ptr=%0h r15=%02h exp ptr=0 r15=ab", ptr, reg_at(15)); else pass_cnt++;
    total++; if (m_axis_tdata !== 8'h00) $display("FAIL pm_rd0 got=%02h exp=00", m_axis_tdata); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0; bus_addressed = 1'b1;
    hw_we = 1'b0; hw_addr = '0; hw_data = 8'h00;
    test_reset();
    test_basic_write();
    test_read_wrap();
    test_bus_release();
    test_hw_collision();
    test_simul_rw();
    test_reset_mid();
    test_ptr_mask();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
